// File: rtl/ppu_update_tx_if.sv
// Bus bundle for ppu_update_tx: the CPU command-write side, the status flags
// and the PPU square-update beat fields.
// fsm_state mirrors the transmitter FSM state: 0 IDLE, 1 SINGLE, 2 SHIP, 3 CLEAR.
interface ppu_update_tx_if;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        err_clr;
  logic        full;
  logic        busy;
  logic [1:0]  err;
  logic        receive;
  logic        board;
  logic [6:0]  square_update;
  logic [1:0]  square_state;
  logic [1:0]  ship_type;
  logic [2:0]  ship_section;
  logic        vert;
  logic        square_sel;
  logic [1:0]  fsm_state;

  modport master (
    output wr_en, wr_data, err_clr,
    input  full, busy, err, receive, board, square_update, square_state,
           ship_type, ship_section, vert, square_sel, fsm_state
  );

  modport slave (
    input  wr_en, wr_data, err_clr,
    output full, busy, err, receive, board, square_update, square_state,
           ship_type, ship_section, vert, square_sel, fsm_state
  );
endinterface

// File: rtl/ppu_update_tx.sv
// PPU square-update transmitter: a command FIFO feeding an FSM that turns each
// command word into one or more single-cycle receive beats. SHIP and CLEAR
// commands are expanded into per-square beats in hardware.
// Optional feature macro: PPU_TX_BOUNDS_CHECK_EN (drop out-of-board SINGLE/SHIP
// commands with err[0]); undefined means unchecked, 7-bit truncated squares.
module ppu_update_tx #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic           sys_clk,
  input  logic           rst,
  ppu_update_tx_if.slave bus
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SINGLE = 2'd1,
    S_SHIP   = 2'd2,
    S_CLEAR  = 2'd3
  } state_t;

  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d, busy_q, busy_d;
  logic [1:0]    err_q, err_d;
  state_t        state_q, state_d;
  logic [6:0]    bow_q, bow_d;
  logic [6:0]    cnt_q, cnt_d;
  logic          receive_q, receive_d, board_q, board_d;
  logic          vert_q, vert_d, sel_q, sel_d;
  logic [6:0]    square_q, square_d;
  logic [1:0]    sstate_q, sstate_d, type_q, type_d;
  logic [2:0]    section_q, section_d;
  logic          push, pop, bad_cmd;
  logic          single_oob, ship_oob;
  logic [31:0]   head;
  logic [6:0]    ship_last, ship_step;
  logic          unused_head;

  assign head        = mem_q[rd_ptr_q];
  assign unused_head = ^head[29:17];

`ifdef PPU_TX_BOUNDS_CHECK_EN
  logic [6:0] ship_len, bow_col, bow_row;
  // Reject commands whose squares would leave the 10x10 board.
  always_comb begin
    ship_len   = {5'b0, head[6:5]} + 7'd2;
    bow_col    = head[15:9] % 7'd10;
    bow_row    = head[15:9] / 7'd10;
    single_oob = head[15:9] > 7'd99;
    if (head[1]) ship_oob = ((bow_row + ship_len) > 7'd10) || single_oob;
    else         ship_oob = (bow_col + ship_len) > 7'd10;
  end
`else
  // Without bounds checking every SINGLE/SHIP is emitted as written.
  always_comb begin
    single_oob = 1'b0;
    ship_oob   = 1'b0;
  end
`endif

  // Command FIFO bookkeeping and status flags.
  // Handshake: a write is taken on any cycle with wr_en=1 and full=0; wr_en
  // while full drops the word and raises err[1]. full is registered, so a pop
  // in the same cycle does not make room for that write.
  always_comb begin
    push     = bus.wr_en && !full_q;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
    full_d = (count_d == DEPTH_C);
    busy_d = (count_d != '0) || (state_d != S_IDLE);
    err_d  = bus.err_clr ? 2'b00 : err_q;
    err_d[0] = err_d[0] | bad_cmd;
    err_d[1] = err_d[1] | (bus.wr_en && full_q);
  end

  // Transmit FSM: IDLE pops and emits the first beat of a command directly,
  // so the beat register and state register stay aligned.
  always_comb begin
    state_d   = state_q;
    bow_d     = bow_q;
    cnt_d     = cnt_q;
    pop       = 1'b0;
    bad_cmd   = 1'b0;
    receive_d = 1'b0;
    board_d   = board_q;
    square_d  = square_q;
    sstate_d  = sstate_q;
    type_d    = type_q;
    section_d = section_q;
    vert_d    = vert_q;
    sel_d     = sel_q;
    ship_last = {5'b0, type_q} + 7'd1;
    ship_step = 7'd0;
    unique case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop   = 1'b1;
          bow_d = head[15:9];
          cnt_d = 7'd0;
          unique case (head[31:30])
            2'b00: begin
              if (single_oob) begin
                bad_cmd = 1'b1;
              end else begin
                state_d   = S_SINGLE;
                receive_d = 1'b1;
                board_d   = head[16];
                square_d  = head[15:9];
                sstate_d  = head[8:7];
                type_d    = head[6:5];
                section_d = head[4:2];
                vert_d    = head[1];
                sel_d     = head[0];
              end
            end
            2'b01: begin
              if (ship_oob) begin
                bad_cmd = 1'b1;
              end else begin
                state_d   = S_SHIP;
                receive_d = 1'b1;
                board_d   = head[16];
                square_d  = head[15:9];
                sstate_d  = 2'b11;
                type_d    = head[6:5];
                section_d = 3'd0;
                vert_d    = head[1];
                sel_d     = 1'b0;
              end
            end
            2'b10: begin
              state_d   = S_CLEAR;
              receive_d = 1'b1;
              board_d   = head[16];
              square_d  = 7'd0;
              sstate_d  = 2'b00;
              type_d    = 2'b00;
              section_d = 3'd0;
              vert_d    = 1'b0;
              sel_d     = 1'b0;
            end
            default: bad_cmd = 1'b1;
          endcase
        end
      end
      S_SINGLE: state_d = S_IDLE;
      S_SHIP: begin
        if (cnt_q == ship_last) begin
          state_d = S_IDLE;
        end else begin
          cnt_d     = cnt_q + 7'd1;
          ship_step = vert_q ? cnt_d * 7'd10 : cnt_d;
          receive_d = 1'b1;
          square_d  = bow_q + ship_step;
          section_d = cnt_d[2:0];
        end
      end
      S_CLEAR: begin
        if (cnt_q == 7'd99) begin
          state_d = S_IDLE;
        end else begin
          cnt_d     = cnt_q + 7'd1;
          receive_d = 1'b1;
          square_d  = cnt_d;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, FIFO pointers, flags and beat fields; reset clears everything.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 2'b00;
      state_q   <= S_IDLE;
      bow_q     <= 7'd0;
      cnt_q     <= 7'd0;
      receive_q <= 1'b0;
      board_q   <= 1'b0;
      square_q  <= 7'd0;
      sstate_q  <= 2'b00;
      type_q    <= 2'b00;
      section_q <= 3'd0;
      vert_q    <= 1'b0;
      sel_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      full_q    <= full_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      state_q   <= state_d;
      bow_q     <= bow_d;
      cnt_q     <= cnt_d;
      receive_q <= receive_d;
      board_q   <= board_d;
      square_q  <= square_d;
      sstate_q  <= sstate_d;
      type_q    <= type_d;
      section_q <= section_d;
      vert_q    <= vert_d;
      sel_q     <= sel_d;
    end
  end

  // FIFO storage needs no reset: only entries below count are ever read.
  always_ff @(posedge sys_clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.wr_data;
  end

  assign bus.full          = full_q;
  assign bus.busy          = busy_q;
  assign bus.err           = err_q;
  assign bus.receive       = receive_q;
  assign bus.board         = board_q;
  assign bus.square_update = square_q;
  assign bus.square_state  = sstate_q;
  assign bus.ship_type     = type_q;
  assign bus.ship_section  = section_q;
  assign bus.vert          = vert_q;
  assign bus.square_sel    = sel_q;
  assign bus.fsm_state     = state_q;
endmodule

// File: tb/tb_ppu_update_tx.sv
// Directed bench for ppu_update_tx: hand-computed beat lists go into an
// expected queue, a negedge monitor checks every receive beat against it.
module tb_ppu_update_tx;
  localparam int W = 17;

  logic sys_clk = 1'b0;
  logic rst     = 1'b1;
  int   n_cmp   = 0;
  int   n_err   = 0;
  logic [W-1:0] exp_q[$];

  ppu_update_tx_if bus();

  ppu_update_tx #(.FIFO_DEPTH(8)) dut (
    .sys_clk (sys_clk),
    .rst     (rst),
    .bus     (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 sys_clk = ~sys_clk;

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] cmd(input logic [1:0] op, input logic b,
                                      input logic [6:0] sq, input logic [1:0] st,
                                      input logic [1:0] ty, input logic [2:0] sec,
                                      input logic v, input logic s);
    return {op, 13'b0, b, sq, st, ty, sec, v, s};
  endfunction

  function automatic logic [W-1:0] beat(input logic b, input logic [6:0] sq,
                                        input logic [1:0] st, input logic [1:0] ty,
                                        input logic [2:0] sec, input logic v,
                                        input logic s);
    return {b, sq, st, ty, sec, v, s};
  endfunction

  function automatic logic [W-1:0] cur_beat();
    return {bus.board, bus.square_update, bus.square_state, bus.ship_type,
            bus.ship_section, bus.vert, bus.square_sel};
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge sys_clk) begin
    if (bus.receive === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("beat_unexpected", 32'(bus.receive), 32'd0);
      end else begin
        check("beat", 32'(cur_beat()), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic write(input logic [31:0] w);
    bus.wr_en   = 1'b1;
    bus.wr_data = w;
    step();
    bus.wr_en   = 1'b0;
  endtask

  task automatic clear_err();
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while ((bus.busy !== 1'b0 || exp_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    check({tag, "_drain"}, 32'((bus.busy === 1'b0) && (exp_q.size() == 0)), 32'd1);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int n;
    bus.wr_en   = 1'b0;
    bus.wr_data = 32'd0;
    bus.err_clr = 1'b0;
    rst         = 1'b1;
    repeat (3) step();
    check("rst_rx", 32'(bus.receive), 32'd0);
    check("rst_fields", 32'(cur_beat()), 32'd0);
    check("rst_flags", 32'({bus.full, bus.busy, bus.err}), 32'd0);
    rst = 1'b0;
    step();

    // SINGLE: board 1, sq 69, state 11, vert 1, sel 1; beat two cycles after write
    exp_q.push_back(beat(1'b1, 7'd69, 2'b11, 2'b00, 3'd0, 1'b1, 1'b1));
    write(32'h0001_8B83);
    check("single_pop_rx", 32'(bus.receive), 32'd0);
    step();
    check("single_rx", 32'(bus.receive), 32'd1);
    check("single_fields", 32'(cur_beat()), 32'(beat(1'b1, 7'd69, 2'b11, 2'b00, 3'd0, 1'b1, 1'b1)));
    step();
    check("single_busy", 32'(bus.busy), 32'd0);
    check("single_rx_end", 32'(bus.receive), 32'd0);

    // SHIP horizontal: sq 23, type 3 -> squares 23..27 back-to-back
    for (int k = 0; k < 5; k++)
      exp_q.push_back(beat(1'b0, 7'(23 + k), 2'b11, 2'b11, 3'(k), 1'b0, 1'b0));
    write(cmd(2'b01, 1'b0, 7'd23, 2'b01, 2'b11, 3'd7, 1'b0, 1'b1));
    step();
    for (int k = 0; k < 5; k++) begin
      check("ship_h_rx", 32'(bus.receive), 32'd1);
      check("ship_h_sq", 32'(bus.square_update), 32'(23 + k));
      step();
    end
    check("ship_h_end", 32'(bus.receive), 32'd0);
    drain("ship_h", 20);

    // SHIP vertical: sq 4, type 1 -> squares 4, 14, 24
    exp_q.push_back(beat(1'b1, 7'd4,  2'b11, 2'b01, 3'd0, 1'b1, 1'b0));
    exp_q.push_back(beat(1'b1, 7'd14, 2'b11, 2'b01, 3'd1, 1'b1, 1'b0));
    exp_q.push_back(beat(1'b1, 7'd24, 2'b11, 2'b01, 3'd2, 1'b1, 1'b0));
    write(cmd(2'b01, 1'b1, 7'd4, 2'b00, 2'b01, 3'd0, 1'b1, 1'b0));
    drain("ship_v", 20);
    check("ship_v_err", 32'(bus.err), 32'd0);

    // Vertical ship from sq 75, length 5 runs off the bottom edge
`ifdef PPU_TX_BOUNDS_CHECK_EN
    write(cmd(2'b01, 1'b0, 7'd75, 2'b00, 2'b11, 3'd0, 1'b1, 1'b0));
    drain("ship_oob", 20);
    check("ship_oob_err", 32'(bus.err), 32'd1);
    clear_err();
    check("ship_oob_clr", 32'(bus.err), 32'd0);
    write(cmd(2'b00, 1'b0, 7'd100, 2'b01, 2'b00, 3'd0, 1'b0, 1'b0));
    drain("single_oob", 20);
    check("single_oob_err", 32'(bus.err), 32'd1);
    clear_err();
`else
    exp_q.push_back(beat(1'b0, 7'd75,  2'b11, 2'b11, 3'd0, 1'b1, 1'b0));
    exp_q.push_back(beat(1'b0, 7'd85,  2'b11, 2'b11, 3'd1, 1'b1, 1'b0));
    exp_q.push_back(beat(1'b0, 7'd95,  2'b11, 2'b11, 3'd2, 1'b1, 1'b0));
    exp_q.push_back(beat(1'b0, 7'd105, 2'b11, 2'b11, 3'd3, 1'b1, 1'b0));
    exp_q.push_back(beat(1'b0, 7'd115, 2'b11, 2'b11, 3'd4, 1'b1, 1'b0));
    write(cmd(2'b01, 1'b0, 7'd75, 2'b00, 2'b11, 3'd0, 1'b1, 1'b0));
    drain("ship_oob", 20);
    check("ship_oob_err", 32'(bus.err), 32'd0);
    exp_q.push_back(beat(1'b0, 7'd100, 2'b01, 2'b00, 3'd0, 1'b0, 1'b0));
    write(cmd(2'b00, 1'b0, 7'd100, 2'b01, 2'b00, 3'd0, 1'b0, 1'b0));
    drain("single_oob", 20);
    check("single_oob_err", 32'(bus.err), 32'd0);
`endif

    // FIFO overflow while a CLEAR runs: 9 back-to-back SINGLE writes
    for (int k = 0; k < 100; k++)
      exp_q.push_back(beat(1'b1, 7'(k), 2'b00, 2'b00, 3'd0, 1'b0, 1'b0));
    write(cmd(2'b10, 1'b1, 7'd55, 2'b11, 2'b11, 3'd5, 1'b1, 1'b1));
    step();
    step();
    for (int i = 0; i < 8; i++)
      exp_q.push_back(beat(1'b0, 7'(10 + i), 2'(i), 2'b10, 3'(i), 1'b0, 1'(i)));
    bus.wr_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bus.wr_data = cmd(2'b00, 1'b0, 7'(10 + i), 2'(i), 2'b10, 3'(i), 1'b0, 1'(i));
      step();
      if (i == 6) check("fifo_not_full", 32'(bus.full), 32'd0);
      if (i == 7) check("fifo_full", 32'(bus.full), 32'd1);
    end
    bus.wr_en = 1'b0;
    check("fifo_err1", 32'(bus.err), 32'd2);
    drain("fifo", 400);
    check("fifo_full_end", 32'(bus.full), 32'd0);
    clear_err();
    check("fifo_err_clr", 32'(bus.err), 32'd0);

    // Reset at beat 40 of a CLEAR abandons the remaining 59 beats
    for (int k = 0; k < 100; k++)
      exp_q.push_back(beat(1'b0, 7'(k), 2'b00, 2'b00, 3'd0, 1'b0, 1'b0));
    write(cmd(2'b10, 1'b0, 7'd0, 2'b00, 2'b00, 3'd0, 1'b0, 1'b0));
    n = 0;
    while (!(bus.receive === 1'b1 && bus.square_update == 7'd40) && n < 200) begin
      step();
      n++;
    end
    check("rst_mid_reach40", 32'(bus.square_update), 32'd40);
    rst = 1'b1;
    step();
    check("rst_mid_rx", 32'(bus.receive), 32'd0);
    check("rst_mid_fields", 32'(cur_beat()), 32'd0);
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    check("rst_mid_left", 32'(exp_q.size()), 32'd59);
    exp_q.delete();
    rst = 1'b0;
    repeat (5) step();
    check("rst_mid_quiet", 32'(bus.receive), 32'd0);
    exp_q.push_back(beat(1'b0, 7'd99, 2'b10, 2'b01, 3'd3, 1'b0, 1'b1));
    write(cmd(2'b00, 1'b0, 7'd99, 2'b10, 2'b01, 3'd3, 1'b0, 1'b1));
    drain("rst_after", 20);

    // Reserved opcode, err_clr alone, err_clr colliding with a new error
    write(cmd(2'b11, 1'b0, 7'd5, 2'b01, 2'b00, 3'd0, 1'b0, 1'b0));
    drain("bad_op", 20);
    check("bad_op_err", 32'(bus.err), 32'd1);
    clear_err();
    check("err_clr_alone", 32'(bus.err), 32'd0);
    write(cmd(2'b11, 1'b1, 7'd6, 2'b00, 2'b00, 3'd0, 1'b0, 1'b0));
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
    check("err_clr_collide", 32'(bus.err), 32'd1);
    drain("collide", 20);
    clear_err();

    // A dropped command costs only its IDLE cycle
    exp_q.push_back(beat(1'b1, 7'd42, 2'b01, 2'b00, 3'd0, 1'b0, 1'b0));
    bus.wr_en   = 1'b1;
    bus.wr_data = cmd(2'b11, 1'b0, 7'd0, 2'b00, 2'b00, 3'd0, 1'b0, 1'b0);
    step();
    bus.wr_data = cmd(2'b00, 1'b1, 7'd42, 2'b01, 2'b00, 3'd0, 1'b0, 1'b0);
    step();
    bus.wr_en = 1'b0;
    check("drop_gap_rx0", 32'(bus.receive), 32'd0);
    step();
    check("drop_gap_rx1", 32'(bus.receive), 32'd1);
    drain("drop_gap", 20);
    check("drop_gap_err", 32'(bus.err), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
